// File: rtl/acl_frame_fifo_if.sv
// Stream bundle for acl_frame_fifo: RX (write) side from the MAC and
// TX (read) side towards the ACL egress path. The FIFO takes the slave view.
interface acl_frame_fifo_if #(
    parameter int DATA_W = 32
);
    // write side
    logic              i_rxd_tvalid;
    logic              o_rxd_tready;
    logic [DATA_W-1:0] i_rx_data;
    logic              i_rx_tlast;
    logic              i_fifo_invalid;
    // read side
    logic              o_txd_tvalid;
    logic              i_txd_tready;
    logic [DATA_W-1:0] o_data;
    logic              o_tlast;

    modport slave (
        input  i_rxd_tvalid,
        input  i_rx_data,
        input  i_rx_tlast,
        input  i_fifo_invalid,
        input  i_txd_tready,
        output o_rxd_tready,
        output o_txd_tvalid,
        output o_data,
        output o_tlast
    );

    modport master (
        output i_rxd_tvalid,
        output i_rx_data,
        output i_rx_tlast,
        output i_fifo_invalid,
        output i_txd_tready,
        input  o_rxd_tready,
        input  o_txd_tvalid,
        input  o_data,
        input  o_tlast
    );
endinterface

// File: rtl/acl_frame_fifo.sv
// Store-and-forward frame FIFO. Frames are written speculatively past
// commit_ptr and only become readable once their last beat arrives with a
// good ACL verdict; rejected or overflowing frames are rolled back by
// rewinding wr_ptr to commit_ptr. The write side never back-pressures.
module acl_frame_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    acl_frame_fifo_if.slave   bus,
    output logic [ADDR_W:0]   o_wr_cnt,
    output logic [ADDR_W:0]   o_frame_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic              o_overflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        ST_PASS,
        ST_DROP
    } wr_state_e;

    // storage: {tlast, data} per word, no reset (RAM-style)
    logic [DATA_W:0] mem_q [DEPTH];

    // write side state
    wr_state_e       state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic            overflow_q, overflow_d;
    logic            rxd_tready_q, rxd_tready_d;

    // read side state
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] frame_cnt_q, frame_cnt_d;
    logic            txd_tvalid_q, txd_tvalid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic            tlast_q, tlast_d;

    // combinational helpers
    logic            accept;
    logic            full;
    logic [ADDR_W:0] ptr_diff;
    logic            mem_we;
    logic            commit;
    logic            drop_inc;
    logic            pop;

    assign accept   = bus.i_rxd_tvalid & rxd_tready_q;
    // full uses the pre-edge rd_ptr, so a same-cycle pop does not free space
    assign ptr_diff = wr_ptr_q - rd_ptr_q;
    assign full     = (ptr_diff == FULL_LVL);
    assign pop      = txd_tvalid_q & bus.i_txd_tready;

    // write FSM: store, commit, or roll back the frame in flight
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = 1'b0;
        rxd_tready_d = 1'b1;
        mem_we       = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (accept) begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (bus.i_rx_tlast) begin
                            if (!bus.i_fifo_invalid) begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                commit       = 1'b1;
                            end else begin
                                wr_ptr_d = commit_ptr_q;
                                drop_inc = 1'b1;
                            end
                        end
                    end else begin
                        // no room: discard the partial frame and swallow the rest
                        wr_ptr_d   = commit_ptr_q;
                        overflow_d = 1'b1;
                        if (bus.i_rx_tlast) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (accept && bus.i_rx_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
        if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // memory write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {bus.i_rx_tlast, bus.i_rx_data};
        end
    end

    // read side: output register always holds mem[rd_ptr] while valid,
    // refilled from the post-pop pointer so frames stream without bubbles
    always_comb begin
        rd_ptr_d     = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
        txd_tvalid_d = (rd_ptr_d != commit_ptr_q);
        data_d       = data_q;
        tlast_d      = tlast_q;
        if ((!txd_tvalid_q || pop) && txd_tvalid_d) begin
            {tlast_d, data_d} = mem_q[rd_ptr_d[ADDR_W-1:0]];
        end
        frame_cnt_d = frame_cnt_q;
        if (commit && !(pop && tlast_q)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end else if (!commit && pop && tlast_q) begin
            frame_cnt_d = frame_cnt_q - 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PASS;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            rxd_tready_q <= 1'b0;
            rd_ptr_q     <= '0;
            frame_cnt_q  <= '0;
            txd_tvalid_q <= 1'b0;
            data_q       <= '0;
            tlast_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            rxd_tready_q <= rxd_tready_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            txd_tvalid_q <= txd_tvalid_d;
            data_q       <= data_d;
            tlast_q      <= tlast_d;
        end
    end

    assign bus.o_rxd_tready = rxd_tready_q;
    assign bus.o_txd_tvalid = txd_tvalid_q;
    assign bus.o_data       = data_q;
    assign bus.o_tlast      = tlast_q;
    assign o_wr_cnt         = commit_ptr_q - rd_ptr_q;
    assign o_frame_cnt      = frame_cnt_q;
    assign o_drop_cnt       = drop_cnt_q;
    assign o_overflow       = overflow_q;
endmodule

// File: tb/tb_acl_frame_fifo.sv
// Bench for acl_frame_fifo (16-word configuration): frame-level queue model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_acl_frame_fifo;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acl_frame_fifo_if #(.DATA_W(DATA_W)) bus ();
    logic [ADDR_W:0]  o_wr_cnt;
    logic [ADDR_W:0]  o_frame_cnt;
    logic [CNT_W-1:0] o_drop_cnt;
    logic             o_overflow;

    acl_frame_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_wr_cnt(o_wr_cnt), .o_frame_cnt(o_frame_cnt),
        .o_drop_cnt(o_drop_cnt), .o_overflow(o_overflow)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // cq: committed, not yet popped words (head = word on the output)
    // pq: words of the frame currently being received
    logic [DATA_W:0] cq[$];
    logic [DATA_W:0] pq[$];
    logic [DATA_W:0] cm[$];
    bit              m_ready, m_valid, m_drop, m_ovf, m_full, ovf;
    logic [DATA_W:0] m_head;
    int              m_drops;

    function automatic int frames_in_cq();
        int n = 0;
        foreach (cq[i]) if (cq[i][DATA_W]) n++;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        cyc++;
        if (!rst) begin
            cq.delete(); pq.delete(); cm.delete();
            m_ready = 0; m_valid = 0; m_drop = 0; m_ovf = 0; m_drops = 0;
            m_head = '0;
        end else begin
            m_full = (cq.size() + pq.size()) == DEPTH;
            ovf = 0;
            cm.delete();
            if (m_ready && bus.i_rxd_tvalid) begin
                if (m_drop) begin
                    if (bus.i_rx_tlast) begin m_drops++; m_drop = 0; end
                end else if (m_full) begin
                    pq.delete();
                    ovf = 1;
                    if (bus.i_rx_tlast) m_drops++;
                    else m_drop = 1;
                end else begin
                    pq.push_back({bus.i_rx_tlast, bus.i_rx_data});
                    if (bus.i_rx_tlast) begin
                        if (!bus.i_fifo_invalid) cm = pq;
                        else m_drops++;
                        pq.delete();
                    end
                end
            end
            if (m_valid && bus.i_txd_tready) void'(cq.pop_front());
            // words committed at this edge become visible one cycle later
            m_valid = (cq.size() != 0);
            if (m_valid) m_head = cq[0];
            foreach (cm[i]) cq.push_back(cm[i]);
            m_ovf   = ovf;
            m_ready = 1;
        end
    end

    // ---------------- compare + monitor ----------------
    logic [DATA_W:0] cap[$];
    int              capcyc[$];
    int              ovf_seen;
    int              valid_seen;
    int              max_wr;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_rxd_tready", bus.o_rxd_tready, 0);
            check("rst_txd_tvalid", bus.o_txd_tvalid, 0);
            check("rst_data", bus.o_data, 0);
            check("rst_tlast", bus.o_tlast, 0);
            check("rst_wr_cnt", o_wr_cnt, 0);
            check("rst_frame_cnt", o_frame_cnt, 0);
            check("rst_drop_cnt", o_drop_cnt, 0);
            check("rst_overflow", o_overflow, 0);
        end else begin
            check("rxd_tready", bus.o_rxd_tready, m_ready);
            check("txd_tvalid", bus.o_txd_tvalid, m_valid);
            if (m_valid) begin
                check("data", bus.o_data, m_head[DATA_W-1:0]);
                check("tlast", bus.o_tlast, m_head[DATA_W]);
            end
            check("wr_cnt", o_wr_cnt, cq.size());
            check("frame_cnt", o_frame_cnt, frames_in_cq());
            check("drop_cnt", o_drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
            check("overflow", o_overflow, m_ovf);
            if (bus.o_txd_tvalid && bus.i_txd_tready) begin
                cap.push_back({bus.o_tlast, bus.o_data});
                capcyc.push_back(cyc);
            end
            if (bus.o_txd_tvalid) valid_seen++;
            if (o_overflow) ovf_seen++;
            if (int'(o_wr_cnt) > max_wr) max_wr = int'(o_wr_cnt);
        end
    end

    // ---------------- stimulus ----------------
    bit stall_mode = 0;
    bit rand_rdy   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rx();
        bus.i_rxd_tvalid   = 1'b0;
        bus.i_rx_tlast     = 1'b0;
        bus.i_fifo_invalid = 1'b0;
    endtask

    task automatic drive_rdy();
        if (rand_rdy)
            bus.i_txd_tready = stall_mode ? ($urandom_range(0, 7) == 0)
                                          : ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_frame(int len, logic [31:0] base, bit inv);
        for (int i = 0; i < len; i++) begin
            bus.i_rxd_tvalid   = 1'b1;
            bus.i_rx_data      = base + i;
            bus.i_rx_tlast     = (i == len - 1);
            bus.i_fifo_invalid = (i == len - 1) ? inv : 1'($urandom_range(0, 1));
            drive_rdy();
            tick();
        end
        idle_rx();
    endtask

    task automatic wait_drain(int maxc);
        int n = 0;
        bus.i_txd_tready = 1'b1;
        while ((cq.size() != 0) && (n < maxc)) begin
            tick();
            n++;
        end
        check("drain_within_budget", n < maxc, 1);
        tick();
    endtask

    task automatic check_cap(string name, int n, logic [31:0] base);
        check({name, "_count"}, cap.size(), n);
        if (cap.size() == n)
            for (int i = 0; i < n; i++)
                check({name, "_word"}, cap[i], {(i == n - 1), base + i});
    endtask

    initial begin
        int a0;
        bus.i_txd_tready = 1'b0;
        bus.i_rx_data    = '0;
        idle_rx();
        #2 rst = 1'b0;
        repeat (3) tick();
        check("lit_rst_tready", bus.o_rxd_tready, 0);
        check("lit_rst_wr_cnt", o_wr_cnt, 0);
        @(posedge clk); #1 rst = 1'b1;
        check("lit_tready_before_edge", bus.o_rxd_tready, 0);
        tick();
        check("lit_tready_after_edge", bus.o_rxd_tready, 1);
        tick();

        // single 16-word frame
        bus.i_txd_tready = 1'b1;
        cap.delete();
        send_frame(16, 32'h1, 1'b0);
        wait_drain(100);
        check_cap("t1", 16, 32'h1);
        check("t1_drop", o_drop_cnt, 0);

        // rejected frame followed by a good one
        cap.delete(); max_wr = 0;
        send_frame(8, 32'h100, 1'b1);
        send_frame(4, 32'h200, 1'b0);
        wait_drain(100);
        check_cap("t2", 4, 32'h200);
        check("t2_drop", o_drop_cnt, 1);
        check("t2_maxwr_le4", max_wr <= 4, 1);

        // overflow of a 20-word frame with downstream stalled
        bus.i_txd_tready = 1'b0;
        cap.delete(); ovf_seen = 0; valid_seen = 0;
        send_frame(20, 32'h300, 1'b0);
        repeat (3) tick();
        check("t3_ovf_pulses", ovf_seen, 1);
        check("t3_drop", o_drop_cnt, 2);
        check("t3_wr_cnt", o_wr_cnt, 0);
        check("t3_no_valid", valid_seen, 0);
        send_frame(3, 32'h400, 1'b0);
        wait_drain(100);
        check_cap("t3b", 3, 32'h400);

        // back-to-back single-beat frames
        cap.delete(); capcyc.delete();
        bus.i_txd_tready = 1'b1;
        bus.i_rxd_tvalid = 1'b1; bus.i_rx_tlast = 1'b1; bus.i_fifo_invalid = 1'b0;
        bus.i_rx_data = 32'hA; tick(); a0 = cyc;
        bus.i_rx_data = 32'hB; tick();
        bus.i_rx_data = 32'hC; tick();
        idle_rx();
        wait_drain(100);
        check("t4_count", cap.size(), 3);
        if (cap.size() == 3) begin
            check("t4_w0", cap[0], {1'b1, 32'hA});
            check("t4_w1", cap[1], {1'b1, 32'hB});
            check("t4_w2", cap[2], {1'b1, 32'hC});
            check("t4_lat", capcyc[0], a0 + 1);
            check("t4_gap1", capcyc[1], a0 + 2);
            check("t4_gap2", capcyc[2], a0 + 3);
        end

        // stall mid-frame while another frame commits
        cap.delete();
        send_frame(6, 32'h500, 1'b0);
        repeat (3) tick();
        bus.i_txd_tready = 1'b0;
        send_frame(3, 32'h600, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check("t5_hold", bus.o_data, 32'h502);
            tick();
        end
        check("t5_hold_end", bus.o_data, 32'h502);
        wait_drain(100);
        check("t5_count", cap.size(), 9);
        if (cap.size() == 9) begin
            for (int i = 0; i < 6; i++) check("t5_a", cap[i], {(i == 5), 32'h500 + i});
            for (int i = 0; i < 3; i++) check("t5_b", cap[6 + i], {(i == 2), 32'h600 + i});
        end

        // asynchronous reset mid-frame with a committed frame stored
        bus.i_txd_tready = 1'b0;
        send_frame(3, 32'h700, 1'b0);
        bus.i_rxd_tvalid = 1'b1; bus.i_rx_tlast = 1'b0;
        bus.i_rx_data = 32'h800; tick();
        bus.i_rx_data = 32'h801; tick();
        check("t6_pre_valid", bus.o_txd_tvalid, 1);
        check("t6_pre_wr_cnt", o_wr_cnt, 3);
        #3 rst = 1'b0;
        #1;
        check("t6_async_valid", bus.o_txd_tvalid, 0);
        check("t6_async_wr_cnt", o_wr_cnt, 0);
        check("t6_async_frames", o_frame_cnt, 0);
        check("t6_async_drop", o_drop_cnt, 0);
        check("t6_async_ready", bus.o_rxd_tready, 0);
        check("t6_async_data", bus.o_data, 0);
        idle_rx();
        tick();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) tick();
        cap.delete();
        send_frame(5, 32'h900, 1'b0);
        wait_drain(100);
        check_cap("t6", 5, 32'h900);
        check("t6_drop", o_drop_cnt, 0);

        // randomized traffic
        rand_rdy = 1;
        for (int f = 0; f < 150; f++) begin
            stall_mode = ($urandom_range(0, 3) == 0);
            send_frame($urandom_range(1, 20), $urandom, ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 3)) begin
                drive_rdy();
                tick();
            end
        end
        rand_rdy = 0;
        wait_drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/acl_frame_fifo.md
# acl_frame_fifo

Parametrised store-and-forward frame FIFO between the Ethernet RX AXI-Stream interface and the ACL egress path. Buffers whole frames, commits a frame only when its last beat arrives, and discards the frame if the ACL verdict marks it invalid or if the buffer overflows mid-frame. The read side presents committed frames only, so downstream never sees a partial or rejected frame.

## Interface
- DATA_W, 32, data width of i_rx_data / o_data
- ADDR_W, 9, log2 of capacity; capacity = 2^ADDR_W words, each stored with its tlast bit
- CNT_W, 16, width of the saturating drop counter
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset; clears all state
- i_rxd_tvalid  in  1  write beat valid
- o_rxd_tready  out  1  write ready; reset 0, 1 from the first clk edge after rst deasserts
- i_rx_data  in  DATA_W  write data
- i_rx_tlast  in  1  last beat of frame
- i_fifo_invalid  in  1  ACL verdict, sampled only on an accepted tlast beat; 1 = discard frame
- o_txd_tvalid  out  1  read beat valid; reset 0
- i_txd_tready  in  1  downstream ready
- o_data  out  DATA_W  read data; reset 0
- o_tlast  out  1  last beat of output frame; reset 0
- o_wr_cnt  out  ADDR_W+1  committed words not yet popped (commit_ptr - rd_ptr); reset 0
- o_frame_cnt  out  ADDR_W+1  committed frames not fully popped; reset 0
- o_drop_cnt  out  CNT_W  dropped frames, saturates at all-ones; reset 0
- o_overflow  out  1  one-cycle pulse when a frame is dropped for overflow; reset 0

## Operation
- Pointers wr_ptr, commit_ptr, rd_ptr are ADDR_W+1 bits; full when wr_ptr - rd_ptr == 2^ADDR_W; committed-empty when rd_ptr == commit_ptr.
- Accepted beat = i_rxd_tvalid & o_rxd_tready. o_rxd_tready never drops for full: the MAC cannot be stalled, so overflow is handled by dropping.
- Write FSM, reset state PASS:
  - PASS, accepted, not full: write {tlast,data} at wr_ptr, wr_ptr+1. If tlast and i_fifo_invalid=0: commit_ptr <= wr_ptr+1, frame committed. If tlast and i_fifo_invalid=1: wr_ptr <= commit_ptr, o_drop_cnt+1.
  - PASS, accepted, full: wr_ptr <= commit_ptr, o_overflow pulse; if tlast: o_drop_cnt+1, stay PASS; else go DROP.
  - DROP, accepted: beat discarded; on tlast: o_drop_cnt+1, go PASS. i_fifo_invalid ignored.
- Each dropped frame increments o_drop_cnt exactly once.
- Read side: first-word-fall-through with output register; pops on o_txd_tvalid & i_txd_tready; o_tlast is the stored tlast bit. Words beyond commit_ptr are never presented.
- o_frame_cnt: +1 on commit, -1 on pop of a tlast word; both in one cycle = unchanged.
- Reset mid-frame: all frames, partial and committed, lost; first beat after release is start of a new frame.

## Timing
- Accepted tlast at edge N: commit_ptr, o_wr_cnt, o_frame_cnt updated at edge N+1.
- Committed-empty FIFO: first word of a new frame on o_data with o_txd_tvalid=1 after edge N+2.
- Sustained read throughput 1 word/cycle while i_txd_tready=1 and committed data remains; no bubble across frame boundaries.
- o_txd_tvalid/o_data/o_tlast stable while i_txd_tready=0.
- Simultaneous write, commit and pop in one cycle are all honoured; full is evaluated with the pre-edge rd_ptr.
- o_overflow is high exactly one cycle, the cycle after the overflowing beat.

## Test plan
- Reset then one 16-word frame 0x00000001..0x00000010, verdict 0, i_txd_tready=1 -> 16 words in order, o_tlast only on 0x00000010, o_frame_cnt 1 then 0, o_drop_cnt 0.
- Frame of 8 words with i_fifo_invalid=1 on tlast, followed by valid 4-word frame -> only the 4 words appear; o_drop_cnt=1; o_wr_cnt never exceeds 4.
- ADDR_W=4 (16 words), i_txd_tready=0, send 20-word frame -> o_overflow one pulse on word 17, o_drop_cnt=1, o_wr_cnt=0, no o_txd_tvalid; a following 3-word frame is delivered intact.
- Back-to-back single-beat frames 0xA, 0xB, 0xC, i_txd_tready=1 -> three words, each with o_tlast=1, consecutive cycles after latency.
- Hold i_txd_tready=0 for 10 cycles mid-frame, then 1 -> o_data held constant while stalled, no word lost or duplicated, commit and pop in the same cycle leaves o_frame_cnt unchanged.
- Assert rst low mid-frame with a committed frame stored -> all outputs at reset values asynchronously; after release a new 5-word frame is delivered alone.
